pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage that sits directly upstream of the CPU controller. It owns the PC, prefetches the instruction at PC from instruction memory over a req/ack handshake, and loads the instruction register (IR) whose top nibble is the controller's `opcode`. It responds to the controller's `loadIR`, `loadPC`, `incPC` and `selA` strobes, and exports `fetch_busy` so the top level can hold the controller while a fetch is outstanding.

## Interface
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width. Must be at least `ADDR_W + 4`.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `loadIR` input, 1 bit: controller strobe; transfer the prefetch buffer into IR.
- `loadPC` input, 1 bit: controller strobe; when `selA=1`, perform a jump.
- `incPC` input, 1 bit: controller strobe; advance PC by 1.
- `selA` input, 1 bit: jump-target select; only meaningful together with `loadPC`.
- `imem_ack` input, 1 bit: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input, `INSTR_W` bits: fetched instruction.
- `imem_req` output, 1 bit: fetch request.
- `imem_addr` output, `ADDR_W` bits: fetch address; equals `pc` while `imem_req` is high.
- `pc` output, `ADDR_W` bits: address of the instruction held or being fetched in the prefetch buffer.
- `ir` output, `INSTR_W` bits: instruction register.
- `opcode` output, 4 bits: `ir[INSTR_W-1:INSTR_W-4]`. This is combinational from `ir`.
- `ir_valid` output, 1 bit: `ir` holds a loaded instruction.
- `fetch_busy` output, 1 bit: high whenever state ≠ READY.
- `fetch_err` output, 1 bit: sticky timeout flag. Present only with the configuration macro; otherwise tied to 0.

## Operation
- **States:** IDLE, FETCH, DISCARD, READY.
- **Reset** (`rst=1` at an edge), from any state including mid-fetch:
  - state becomes IDLE;
  - `pc=0`, `ir=0`, `ir_valid=0`, `fetch_err=0`;
  - prefetch buffer invalid;
  - `imem_req=0`.
- **IDLE:** with `rst` low, go to FETCH on the next edge.
- **FETCH:**
  - `imem_req=1`, `imem_addr=pc`, both held stable until `imem_ack`.
  - On ack: buffer ← `imem_rdata`, go to READY.
- **READY:**
  - `imem_req=0`.
  - `loadIR`: `ir` ← buffer, `ir_valid` ← 1.
- **PC update**, evaluated in every non-IDLE state:
  - Jump (`loadPC & selA`): `pc` ← `ir[ADDR_W-1:0]`.
  - Otherwise `incPC`: `pc` ← `pc+1`, wrapping from `2^ADDR_W-1` to 0.
  - Jump has priority over `incPC`.
  - `loadPC & !selA` (the controller's load-state strobe) is a no-op for the PC.
- **After any PC change:**
  - The buffer is invalidated.
  - From READY, go to FETCH.
  - From FETCH: if `imem_ack` is high in that same cycle, the data is dropped and the state goes to FETCH with the new `pc`; otherwise go to DISCARD.
  - DISCARD holds `imem_req=1` and `imem_addr` at the old address (latched), waits for ack, drops the data, then goes to FETCH.
  - A further PC change while in DISCARD only updates `pc`.
- **`loadIR` and PC change in the same cycle, in READY:** IR takes the current buffer (the old `pc` instruction), then the refetch starts. This is the normal execute→load sequence.
- **`loadIR` while state ≠ READY:** ignored. `ir` and `ir_valid` are unchanged.
- **Jump target source:** always the current `ir` value, not the new one being loaded in the same cycle.

## Timing
- `imem_req` rises in the first cycle after leaving IDLE, i.e. one cycle after reset deasserts.
- **Fetch latency:**
  - Ack in the same cycle as the first req gives READY on the next edge; `fetch_busy` drops one cycle after ack.
  - Each cycle of ack delay adds one cycle.
- **Refetch after a PC change:** `fetch_busy` rises the cycle after the strobe edge; minimum 2 cycles until READY again.
- **DISCARD:** costs at least one extra fetch round trip.
- `imem_ack` is ignored while `imem_req=0`.
- `ir`, `pc` and `ir_valid` update only on clock edges. `opcode` follows `ir` with no additional latency.

## Configuration
- **`PC_FETCH_TIMEOUT_EN` defined:**
  - A 4-bit counter runs in FETCH and DISCARD and clears on ack or on a state change.
  - On reaching 15 cycles without ack: `fetch_err` ← 1 (sticky until `rst`).
  - The request drops for one cycle, then reissues at the current `pc`. From DISCARD, the reissue goes directly to FETCH.
- **`PC_FETCH_TIMEOUT_EN` undefined:**
  - No counter.
  - `fetch_err` is constant 0.
  - FETCH and DISCARD wait indefinitely for ack.

## Test plan
- **Reset then fetch:**
  - Drive `rst=1` for 2 cycles, then deassert; memory acks immediately with `0x1234`.
  - Required: `imem_req=1` with `addr=0` one cycle after release; READY next cycle.
  - Then `loadIR` → `ir=0x1234`, `opcode=1`, `ir_valid=1`.
- **Sequential run with 3-cycle ack latency:**
  - Pulse `incPC` plus `loadIR` repeatedly.
  - Required: `pc` goes 0→1→2; `fetch_busy` high for exactly 4 cycles per fetch; `ir` takes each word in order.
- **Jump:**
  - `ir=0xF02A`; pulse `loadPC=1`, `selA=1` together with `incPC=1`.
  - Required: `pc=0x2A` (jump wins); next `imem_addr=0x2A`.
- **Flush during outstanding fetch:**
  - Pulse `incPC` while in FETCH at `pc=5` with ack pending.
  - Required: the late ack for address 5 is discarded, a new req is issued at address 6, and the buffer holds the address-6 data.
- **Wrap and ignored loadIR:**
  - `pc=0xFF`, `incPC` → `pc=0x00`.
  - `loadIR` while `fetch_busy=1` → `ir` unchanged.
- **Timeout** (with `PC_FETCH_TIMEOUT_EN`):
  - Never ack.
  - Required: `fetch_err=1` after 15 FETCH cycles; `imem_req` low for 1 cycle, then reasserted at the same address; `rst` clears `fetch_err`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register, instruction prefetch over a req/ack memory port, and the IR feeding the controller.
// Optional macro PC_FETCH_TIMEOUT_EN adds a fetch timeout with a sticky fetch_err flag.
module pc_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loadIR,
    input  logic               loadPC,
    input  logic               incPC,
    input  logic               selA,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic               ir_valid,
    output logic               fetch_busy,
    output logic               fetch_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_READY   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W-1:0]    old_addr_q;
    logic [INSTR_W-1:0]   ir_q;
    logic [INSTR_W-1:0]   buf_q;
    logic                 ir_valid_q;

    logic                 jump;
    logic                 pc_change;
    logic [ADDR_W-1:0]    pc_target;
    logic                 ack_take;
    logic                 timeout;
    logic                 hold;

    // Memory handshake: imem_req stays high with imem_addr stable until imem_ack.
    // An ack counts only in a cycle where imem_req is high; imem_rdata is taken in that cycle.
    assign ack_take  = imem_req & imem_ack;

    assign jump      = loadPC & selA;
    assign pc_change = (state_q != S_IDLE) & (jump | incPC);
    assign pc_target = jump ? ir_q[ADDR_W-1:0] : (pc_q + PC_ONE);

`ifdef PC_FETCH_TIMEOUT_EN
    logic [3:0] tcnt_q;
    logic       hold_q;
    logic       err_q;

    assign hold    = hold_q;
    assign timeout = imem_req & ~imem_ack & (tcnt_q == 4'd14);

    // A timeout drops the request for one cycle (hold) before reissuing at pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 4'd0;
            hold_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= timeout;
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (ack_take || timeout || !imem_req || (state_d != state_q)) begin
                tcnt_q <= 4'd0;
            end else begin
                tcnt_q <= tcnt_q + 4'd1;
            end
        end
    end

    assign fetch_err = err_q;
`else
    assign hold      = 1'b0;
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (timeout) begin
                    state_d = S_FETCH;
                end else if (pc_change) begin
                    // Without an outstanding request (ack now, or in hold) refetch directly.
                    state_d = (ack_take || hold) ? S_FETCH : S_DISCARD;
                end else if (ack_take) begin
                    state_d = S_READY;
                end
            end
            S_DISCARD: begin
                if (ack_take || timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_READY: begin
                if (pc_change) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req   = ((state_q == S_FETCH) || (state_q == S_DISCARD)) & ~hold;
        imem_addr  = (state_q == S_DISCARD) ? old_addr_q : pc_q;
        fetch_busy = (state_q != S_READY);
        dbg_state  = state_q;
    end

    // Datapath: READY always implies the buffer holds the word at pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            old_addr_q <= '0;
            ir_q       <= '0;
            buf_q      <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            if (pc_change) begin
                pc_q <= pc_target;
            end
            if ((state_q == S_READY) && loadIR) begin
                ir_q       <= buf_q;
                ir_valid_q <= 1'b1;
            end
            if ((state_q == S_FETCH) && (state_d == S_DISCARD)) begin
                old_addr_q <= pc_q;
            end
            if ((state_q == S_FETCH) && ack_take && !pc_change) begin
                buf_q <= imem_rdata;
            end
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = ir_q[INSTR_W-1:INSTR_W-4];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random strobes against a request-level model.
// With PC_FETCH_TIMEOUT_EN defined, a timeout scenario is also exercised.
module tb_pc_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          loadIR;
    logic          loadPC;
    logic          incPC;
    logic          selA;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [3:0]    opcode;
    logic          ir_valid;
    logic          fetch_busy;
    logic          fetch_err;
    logic [1:0]    dbg_state;

    pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst(rst), .loadIR(loadIR), .loadPC(loadPC), .incPC(incPC), .selA(selA),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc(pc), .ir(ir), .opcode(opcode), .ir_valid(ir_valid), .fetch_busy(fetch_busy),
        .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b1;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] mem [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: each request is acked after a random number of wait cycles.
    int lat_lo = 0;
    int lat_hi = 0;
    int wait_cnt = 0;
    int cur_lat = 0;
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt == 0) cur_lat = $urandom_range(lat_hi, lat_lo);
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = IW'($urandom);
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'($urandom_range(1, 0));
            imem_rdata = IW'($urandom);
            wait_cnt   = 0;
        end
    end

    // Model: tracks whether the word at pc is held, and whether the outstanding request is stale.
    logic [AW-1:0] m_pc, m_old, mt_np;
    logic [IW-1:0] m_ir, m_buf;
    bit m_irv, m_started, m_have, m_stale;
    bit mt_take, mt_jump, mt_change;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = '0; m_old = '0; m_ir = '0; m_buf = '0;
            m_irv = 0; m_started = 0; m_have = 0; m_stale = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else begin
            mt_take   = imem_ack && !m_have;
            mt_jump   = loadPC && selA;
            mt_change = mt_jump || incPC;
            mt_np     = mt_jump ? m_ir[AW-1:0] : m_pc + 8'd1;
            if (m_have && loadIR) begin
                m_ir  = m_buf;
                m_irv = 1;
            end
            if (m_stale) begin
                if (mt_take) m_stale = 0;
            end else if (!m_have) begin
                if (mt_change) begin
                    if (!mt_take) begin
                        m_stale = 1;
                        m_old   = m_pc;
                    end
                end else if (mt_take) begin
                    m_have = 1;
                    m_buf  = imem_rdata;
                end
            end else if (mt_change) begin
                m_have = 0;
            end
            if (mt_change) m_pc = mt_np;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("ir", ir, m_ir);
            check("ir_valid", ir_valid, m_irv);
            check("opcode", opcode, m_ir[IW-1:IW-4]);
            check("fetch_busy", fetch_busy, !m_have);
            check("imem_req", imem_req, m_started && !m_have);
            if (m_started && !m_have) check("imem_addr", imem_addr, m_stale ? m_old : m_pc);
            check("fetch_err", fetch_err, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input bit lir, input bit lpc, input bit ipc, input bit sa);
        loadIR = lir; loadPC = lpc; incPC = ipc; selA = sa;
        tick();
        loadIR = 0; loadPC = 0; incPC = 0; selA = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (fetch_busy && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) check("wait_ready_bound", fetch_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; loadIR = 0; loadPC = 0; incPC = 0; selA = 0;
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        mem[0] = 16'h1234; mem[1] = 16'h5A01; mem[2] = 16'hF02A;
        mem[5] = 16'hB005; mem[6] = 16'hC006; mem[8'h2A] = 16'h00FF;

        // Reset then immediate-ack fetch
        tick(); tick();
        rst = 0;
        tick();
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 0);
        tick();
        check("t1_ready", fetch_busy, 0);
        pulse(1, 0, 0, 0);
        check("t1_ir", ir, 16'h1234);
        check("t1_opcode", opcode, 4'h1);
        check("t1_ir_valid", ir_valid, 1);

        // Sequential run, 3-cycle ack delay
        lat_lo = 3; lat_hi = 3;
        exp_q = {16'h1234, 16'h5A01, 16'hF02A};
        pulse(1, 0, 1, 0);
        check("t2_ir0", ir, exp_q.pop_front());
        check("t2_pc1", pc, 1);
        wait_ready(n);
        check("t2_busy_cycles_a", n, 4);
        pulse(1, 0, 1, 0);
        check("t2_ir1", ir, exp_q.pop_front());
        check("t2_pc2", pc, 2);
        wait_ready(n);
        check("t2_busy_cycles_b", n, 4);

        // Jump wins over incPC
        pulse(1, 0, 0, 0);
        check("t3_ir", ir, exp_q.pop_front());
        pulse(0, 1, 1, 1);
        check("t3_pc", pc, 8'h2A);
        check("t3_addr", imem_addr, 8'h2A);
        wait_ready(n);

        // Wrap and ignored loadIR
        pulse(1, 0, 0, 0);
        check("t5_ir", ir, 16'h00FF);
        pulse(0, 1, 0, 1);
        check("t5_pc_ff", pc, 8'hFF);
        wait_ready(n);
        pulse(0, 0, 1, 0);
        check("t5_pc_wrap", pc, 8'h00);
        check("t5_busy", fetch_busy, 1);
        pulse(1, 0, 0, 0);
        check("t5_ir_kept", ir, 16'h00FF);
        wait_ready(n);

        // Flush during an outstanding fetch at pc=5
        for (int i = 0; i < 4; i++) begin
            pulse(0, 0, 1, 0);
            wait_ready(n);
        end
        check("t4_pc4", pc, 4);
        pulse(0, 0, 1, 0);
        check("t4_addr5", imem_addr, 5);
        tick();
        pulse(0, 0, 1, 0);
        check("t4_pc6", pc, 6);
        check("t4_discard_addr", imem_addr, 5);
        n = 0;
        while (!(imem_req && imem_addr == 8'd6) && n < 50) begin
            n++;
            tick();
        end
        check("t4_req6", imem_addr, 6);
        wait_ready(n);
        pulse(1, 0, 0, 0);
        check("t4_ir6", ir, 16'hC006);

`ifdef PC_FETCH_TIMEOUT_EN
        // Timeout: never ack
        chk_en = 0;
        lat_lo = 1000; lat_hi = 1000;
        rst = 1; tick(); rst = 0;
        tick();
        for (int i = 0; i < 15; i++) begin
            check("to_req_held", imem_req, 1);
            check("to_err_low", fetch_err, 0);
            tick();
        end
        check("to_err_set", fetch_err, 1);
        check("to_req_drop", imem_req, 0);
        tick();
        check("to_req_again", imem_req, 1);
        check("to_req_addr", imem_addr, 0);
        check("to_err_sticky", fetch_err, 1);
        lat_lo = 0; lat_hi = 4;
        rst = 1; tick(); rst = 0;
        check("to_err_clear", fetch_err, 0);
        chk_en = 1;
`endif

        // Random strobes, latency 0..4, occasional reset
        lat_lo = 0; lat_hi = 4;
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(99, 0) == 0);
            loadIR = 1'($urandom_range(1, 0));
            incPC  = ($urandom_range(9, 0) < 3);
            loadPC = ($urandom_range(9, 0) < 2);
            selA   = 1'($urandom_range(1, 0));
            tick();
        end
        rst = 0; loadIR = 0; loadPC = 0; incPC = 0; selA = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
